// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: a 2-flop synchronizer feeds a start/data/stop FSM.
// The FSM deserializes LSB-first frames and pulses rx_done_tick once per byte.
`timescale 1ns/1ps
module uart_rx_sampler #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OSR     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            busy
);

  localparam int SMAX = (OSR > SB_TICK) ? OSR : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OSR - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state, w_state_next;
  logic              r_rx_meta, r_rx_s;
  logic [SW-1:0]     r_s, w_s_next;
  logic [NW-1:0]     r_n, w_n_next;
  logic [DBIT-1:0]   r_b, w_b_next;
  logic [DBIT-1:0]   r_dout, w_dout_next;
  logic              r_frame_err, w_frame_err_next;
  logic              r_done, w_done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_dout      <= '0;
      r_frame_err <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      r_state     <= w_state_next;
      r_s         <= w_s_next;
      r_n         <= w_n_next;
      r_b         <= w_b_next;
      r_dout      <= w_dout_next;
      r_frame_err <= w_frame_err_next;
      r_done      <= w_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_s_next         = r_s;
    w_n_next         = r_n;
    w_b_next         = r_b;
    w_dout_next      = r_dout;
    w_frame_err_next = r_frame_err;
    w_done_next      = 1'b0;
    case (r_state)
      IDLE: begin
        // Start edge is taken on any clock, not just on a tick.
        if (!r_rx_s) begin
          w_state_next = START;
          w_s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == S_HALF) begin
            if (!r_rx_s) begin
              w_state_next = DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == S_BIT) begin
            w_s_next = '0;
            w_b_next = {r_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_LAST) begin
              w_state_next = STOP;
            end else begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          // A low stop sample still completes the frame, flagged as an error.
          if (r_s == S_STOP) begin
            w_dout_next      = r_b;
            w_frame_err_next = ~r_rx_s;
            w_done_next      = 1'b1;
            w_state_next     = IDLE;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign rx_done_tick = r_done;
  assign dout         = r_dout;
  assign frame_err    = r_frame_err;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: frames driven at 64 clk/bit from a divide-by-4 tick,
// plus glitch, bad stop, back-to-back, reset abort, line break and tick-tied-high cases.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;
  logic       busy;

  uart_rx_sampler #(.DBIT(8), .SB_TICK(16), .OSR(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  // mod_m_counter stand-in (M=4), optionally forced to tick every clock
  logic [1:0] tick_cnt = 2'd0;
  logic       tie_hi   = 1'b0;
  always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
  assign s_tick = tie_hi | (tick_cnt == 2'd3);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Done-pulse monitor
  int         done_cnt      = 0;
  int         last_done_cyc = 0;
  logic [7:0] cap_dout      = 8'h00;
  logic       cap_fe        = 1'b0;
  logic       prev_done     = 1'b0;
  logic       consec_seen   = 1'b0;
  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
      cap_dout      = dout;
      cap_fe        = frame_err;
      if (prev_done) consec_seen = 1'b1;
    end
    prev_done = rx_done_tick;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Low stop bit is released 40 clk in, after its sample point, so the
  // receiver's re-armed start detector sees a clean high line.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int cpb);
    rx = 1'b0;
    cycles(cpb);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cycles(cpb);
    end
    if (stop) begin
      rx = 1'b1;
      cycles(cpb);
    end else begin
      rx = 1'b0;
      cycles(40);
      rx = 1'b1;
      cycles(cpb - 40);
    end
    rx = 1'b1;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 3000) begin
      cycles(1);
      k++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int first_cyc;
    reset = 1'b1;
    rx    = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    chk("rst_dout", dout, 8'h00);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", rx_done_tick, 1'b0);

    // T1: 0xA5 good frame
    cycles(640);
    send_byte(8'hA5, 1'b1, 64);
    cycles(64);
    chk("t1_count", done_cnt, 1);
    chk("t1_cap_dout", cap_dout, 8'hA5);
    chk("t1_cap_fe", cap_fe, 1'b0);
    chk("t1_dout_held", dout, 8'hA5);
    chk("t1_busy", busy, 1'b0);
    $display("T1 frame 0xA5: dout=%0h frame_err=%0b dones=%0d", dout, frame_err, done_cnt);

    // T2: short low glitch
    base = done_cnt;
    rx = 1'b0;
    cycles(12);
    chk("t2_busy_in", busy, 1'b1);
    rx = 1'b1;
    cycles(40);
    chk("t2_busy_out", busy, 1'b0);
    chk("t2_count", done_cnt, base);
    chk("t2_dout", dout, 8'hA5);
    $display("T2 glitch: busy=%0b dones=%0d dout=%0h", busy, done_cnt, dout);

    // T3: bad stop then good stop
    cycles(128);
    base = done_cnt;
    send_byte(8'h3C, 1'b0, 64);
    cycles(64);
    chk("t3_count_bad", done_cnt, base + 1);
    chk("t3_dout_bad", cap_dout, 8'h3C);
    chk("t3_fe_bad", frame_err, 1'b1);
    chk("t3_busy_bad", busy, 1'b0);
    $display("T3 bad stop 0x3C: dout=%0h frame_err=%0b", dout, frame_err);
    cycles(128);
    send_byte(8'h3C, 1'b1, 64);
    cycles(64);
    chk("t3_count_good", done_cnt, base + 2);
    chk("t3_dout_good", dout, 8'h3C);
    chk("t3_fe_good", frame_err, 1'b0);
    $display("T3 good stop 0x3C: dout=%0h frame_err=%0b", dout, frame_err);

    // T4: back-to-back 0x00, 0xFF
    cycles(128);
    base = done_cnt;
    send_byte(8'h00, 1'b1, 64);
    chk("t4_count1", done_cnt, base + 1);
    chk("t4_dout1", cap_dout, 8'h00);
    chk("t4_fe1", cap_fe, 1'b0);
    first_cyc = last_done_cyc;
    send_byte(8'hFF, 1'b1, 64);
    cycles(64);
    chk("t4_count2", done_cnt, base + 2);
    chk("t4_dout2", dout, 8'hFF);
    chk("t4_fe2", frame_err, 1'b0);
    chk("t4_gap_ok", ((last_done_cyc - first_cyc) >= 636) && ((last_done_cyc - first_cyc) <= 644), 1'b1);
    $display("T4 back-to-back: dout=%0h gap=%0d clk", dout, last_done_cyc - first_cyc);

    // T5: reset during data bit 4 of 0x81, then 0x5A
    cycles(128);
    base = done_cnt;
    rx = 1'b0; cycles(64);
    rx = 1'b1; cycles(64);
    rx = 1'b0; cycles(64);
    rx = 1'b0; cycles(64);
    rx = 1'b0; cycles(64);
    rx = 1'b0; cycles(20);
    chk("t5_busy_pre", busy, 1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk("t5_rst_dout", dout, 8'h00);
    chk("t5_rst_fe", frame_err, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", rx_done_tick, 1'b0);
    cycles(640);
    chk("t5_no_done", done_cnt, base);
    send_byte(8'h5A, 1'b1, 64);
    cycles(64);
    chk("t5_count", done_cnt, base + 1);
    chk("t5_dout", dout, 8'h5A);
    chk("t5_fe", frame_err, 1'b0);
    $display("T5 reset abort then 0x5A: dout=%0h dones=%0d", dout, done_cnt - base);

    // Break: line held low yields repeating 0x00/frame_err frames, no lockup
    cycles(64);
    base = done_cnt;
    rx = 1'b0;
    wait_done(base + 2);
    rx = 1'b1;
    chk("brk_reached", done_cnt >= base + 2, 1'b1);
    cycles(300);
    chk("brk_count", done_cnt, base + 2);
    chk("brk_dout", cap_dout, 8'h00);
    chk("brk_fe", cap_fe, 1'b1);
    chk("brk_busy", busy, 1'b0);
    $display("BRK line low: dones=%0d dout=%0h frame_err=%0b", done_cnt - base, cap_dout, cap_fe);

    // T6: s_tick tied high, 16 clk per bit
    cycles(64);
    tie_hi = 1'b1;
    cycles(32);
    base = done_cnt;
    send_byte(8'h96, 1'b1, 16);
    cycles(32);
    chk("t6_count", done_cnt, base + 1);
    chk("t6_dout", dout, 8'h96);
    chk("t6_fe", frame_err, 1'b0);
    chk("t6_busy", busy, 1'b0);
    tie_hi = 1'b0;
    $display("T6 tick tied high 0x96: dout=%0h dones=%0d", dout, done_cnt - base);

    chk("no_consec_done", consec_seen, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
